// File: rtl/ifu_fetch.sv
// Instruction fetch: one AXI4-lite read per accepted PC, result handed to decode.
// Optional IFU_FAULT_EN reports bus errors and misaligned PCs via inst_fault.
module ifu_fetch #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] pc_in,
    input  logic                  pc_ready,
    input  logic                  flush,
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    output logic                  rready,
    output logic [31:0]           inst,
    output logic [DATA_WIDTH-1:0] inst_pc,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic                  inst_fault
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_HOLD
    } state_t;

    state_t state, state_nx;

    logic [DATA_WIDTH-1:0] req_pc, req_pc_nx;
    logic [ADDR_WIDTH-1:0] araddr_nx;
    logic                  arvalid_nx;
    logic                  rready_nx;
    logic [31:0]           inst_nx;
    logic [DATA_WIDTH-1:0] inst_pc_nx;
    logic                  inst_valid_nx;
    logic                  inst_fault_nx;
    logic                  drop, drop_nx;

    logic                  misaligned;
    logic                  rd_fault;
    logic [ADDR_WIDTH-1:0] pc_addr;

`ifdef IFU_FAULT_EN
    assign misaligned = (pc_in[1:0] != 2'b00);
    assign rd_fault   = (rresp != 2'b00) || (req_pc[1:0] != 2'b00);
    assign pc_addr    = pc_in[ADDR_WIDTH-1:0];
`else
    logic unused_rresp;
    assign unused_rresp = ^rresp;
    assign misaligned   = 1'b0;
    assign rd_fault     = 1'b0;
    assign pc_addr      = {pc_in[ADDR_WIDTH-1:2], 2'b00};
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            req_pc     <= '0;
            araddr     <= '0;
            arvalid    <= 1'b0;
            rready     <= 1'b0;
            inst       <= '0;
            inst_pc    <= '0;
            inst_valid <= 1'b0;
            inst_fault <= 1'b0;
            drop       <= 1'b0;
        end else begin
            state      <= state_nx;
            req_pc     <= req_pc_nx;
            araddr     <= araddr_nx;
            arvalid    <= arvalid_nx;
            rready     <= rready_nx;
            inst       <= inst_nx;
            inst_pc    <= inst_pc_nx;
            inst_valid <= inst_valid_nx;
            inst_fault <= inst_fault_nx;
            drop       <= drop_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: if (pc_ready) state_nx = misaligned ? S_HOLD : S_ADDR;
            S_ADDR: if (arready) state_nx = S_DATA;
            S_DATA: if (rvalid) state_nx = (drop || flush) ? S_IDLE : S_HOLD;
            S_HOLD: if (inst_ready || flush) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        req_pc_nx     = req_pc;
        araddr_nx     = araddr;
        arvalid_nx    = arvalid;
        rready_nx     = rready;
        inst_nx       = inst;
        inst_pc_nx    = inst_pc;
        inst_valid_nx = inst_valid;
        inst_fault_nx = inst_fault;
        drop_nx       = drop;
        unique case (state)
            S_IDLE: begin
                if (pc_ready) begin
                    req_pc_nx = pc_in;
                    if (misaligned) begin
                        inst_nx       = '0;
                        inst_pc_nx    = pc_in;
                        inst_valid_nx = 1'b1;
                        inst_fault_nx = 1'b1;
                    end else begin
                        araddr_nx  = pc_addr;
                        arvalid_nx = 1'b1;
                    end
                end
            end
            S_ADDR: begin
                if (flush) drop_nx = 1'b1;
                if (arready) begin
                    arvalid_nx = 1'b0;
                    rready_nx  = 1'b1;
                end
            end
            S_DATA: begin
                if (flush) drop_nx = 1'b1;
                // a flush landing with rvalid still discards this beat
                if (rvalid) begin
                    rready_nx = 1'b0;
                    drop_nx   = 1'b0;
                    if (!drop && !flush) begin
                        inst_nx       = rdata[31:0];
                        inst_pc_nx    = req_pc;
                        inst_valid_nx = 1'b1;
                        inst_fault_nx = rd_fault;
                    end
                end
            end
            S_HOLD: begin
                if (inst_ready || flush) begin
                    inst_valid_nx = 1'b0;
                    inst_fault_nx = 1'b0;
                end
            end
            default: ;
        endcase
    end

`ifndef SYNTHESIS
    a_pc_ready_idle: assert property (
        @(posedge clk) disable iff (!rst)
        (state == S_IDLE) || !pc_ready
    );
`endif

endmodule
